pulse_generator_prog: RTL and testbench
=======================================

Name: pulse_generator_prog

Overview:
- Runtime-programmable successor to the fixed-tick monostable. One delayed output pulse per trigger edge, in one of three modes: one-shot, retriggerable, or periodic burst.
- Offset, width, period and repeat count are ports, not parameters. They are latched when a trigger is accepted.
- Adds busy/done status, abort, config-error detection and a pulse counter.
- Feeds the stimulus path of the propagation-time meter; o_Done marks the end of an emission window.

Parameters:
- CNT_WIDTH, 38, width of offset/width/period counters (2^38 ticks ≈ 5500 s at 50 MHz).
- REP_WIDTH, 16, width of the repeat-count input and o_Pulse_Count.

Ports:
- i_Clk  in  1  system clock.
- i_Rst  in  1  synchronous, active-high reset.
- i_Trigger  in  1  level input; a rising edge is detected internally.
- i_Abort  in  1  stops the sequence immediately.
- i_Mode  in  2  0 = one-shot, 1 = retriggerable, 2 = periodic burst, 3 = reserved.
- i_Offset  in  CNT_WIDTH  ticks from trigger to pulse start.
- i_Width  in  CNT_WIDTH  high ticks per pulse.
- i_Period  in  CNT_WIDTH  rising-to-rising ticks (mode 2 only).
- i_Repeat  in  REP_WIDTH  pulses per burst (mode 2); 0 = infinite.
- o_Signal  out  1  pulse output, registered.
- o_Busy  out  1  high whenever state ≠ IDLE.
- o_Done  out  1  one-cycle strobe when a sequence completes normally.
- o_Cfg_Err  out  1  sticky; cleared by reset or by the next valid trigger.
- o_Pulse_Count  out  REP_WIDTH  pulses emitted since the last accepted trigger; saturates at all-ones.

Behaviour:
- Reset: i_Rst high at a clock edge sets state = IDLE and clears every output and the edge-detect register on that edge. This includes mid-sequence.
- Edge detect: trig_edge = i_Trigger & ~trig_q. trig_q is a register of i_Trigger, reset to 0.
- FSM states: IDLE, OFFSET, HIGH, GAP.
- Accept:
  - A trig_edge in IDLE at cycle T latches mode, offset, width, period and repeat, and clears o_Pulse_Count.
  - The sequence starts only if the config is valid.
- Config errors (no pulse, state stays IDLE, o_Cfg_Err = 1 at T+1):
  - Width = 0.
  - Mode = 3.
  - Mode 2 with Period ≤ Width.
- Timing:
  - o_Signal is high at cycles T+1+Offset through T+Offset+Width inclusive.
  - Offset = 0 gives o_Signal high from T+1.
  - Offset > 0: state = OFFSET for Offset cycles, down-counter loaded with Offset.
- HIGH state: lasts Width cycles. o_Pulse_Count increments on entry to HIGH.
- Mode 0, one-shot:
  - Triggers are ignored while busy.
  - After HIGH: state returns to IDLE, o_Signal drops, o_Done = 1 for that one cycle.
- Mode 1, retriggerable:
  - A trig_edge in OFFSET reloads the offset counter.
  - A trig_edge in HIGH reloads the width counter; o_Signal stays high with no glitch.
  - A retrigger does not increment o_Pulse_Count.
- Mode 2, periodic burst:
  - After HIGH, state = GAP for Period − Width cycles, then HIGH again.
  - The burst ends after Repeat pulses; Done follows the last pulse.
  - Repeat = 0 runs until abort.
  - Triggers are ignored while busy.
- Abort: i_Abort high at a clock edge forces IDLE and o_Signal = 0 on that edge, with no o_Done.
- Priority: i_Rst > i_Abort > trigger.
  - Abort and trig_edge in the same IDLE cycle: trigger is not accepted.
- Back-to-back: a trig_edge in the o_Done cycle is accepted, because state is already IDLE.
- Counters load (value − 1) and count down to 0. Counters cannot overflow; o_Pulse_Count saturates.
- Inputs other than i_Trigger and i_Abort are ignored outside the accept cycle.

Decomposition:
- Package pulse_gen_pkg holds:
  - mode constants MODE_ONESHOT = 0, MODE_RETRIG = 1, MODE_BURST = 2;
  - FSM state encodings;
  - default CNT_WIDTH and REP_WIDTH.
- One sub-module, tick_down_counter: parametrised width, load/enable inputs, zero flag. Instantiated once and shared across OFFSET/HIGH/GAP, since only one is active at a time.

Test Plan:
- Mode 0, Offset = 3, Width = 5, trigger edge at T → o_Signal high T+4..T+8; o_Done at T+9; o_Busy T+1..T+8; o_Pulse_Count = 1.
- Mode 1, Offset = 0, Width = 4, second edge at T+3 → o_Signal high T+1..T+7 continuously; single o_Done at T+8; o_Pulse_Count = 1.
- Mode 2, Offset = 1, Width = 2, Period = 5, Repeat = 3, edge at T:
  - o_Signal high T+2..T+3, T+7..T+8, T+12..T+13;
  - o_Done at T+14; o_Pulse_Count = 3.
- Config errors: Width = 0 → o_Cfg_Err at T+1, o_Busy stays 0. Mode 2 with Period = Width = 4 → same. A following valid trigger clears o_Cfg_Err.
- Interrupts:
  - Mode 2, Repeat = 0: i_Abort during HIGH → o_Signal low next cycle, IDLE, no o_Done.
  - i_Rst asserted in the OFFSET state → all outputs 0 next cycle.
- Edge cases:
  - i_Trigger held high for 20 cycles in mode 0, Width = 2 → exactly one pulse.
  - New edge in the o_Done cycle → second sequence starts with correct timing.

Source files
------------

// File: rtl/pulse_gen_pkg.sv
// Shared constants and types for the programmable pulse generator.
package pulse_gen_pkg;

    localparam int unsigned DEF_CNT_WIDTH = 38;
    localparam int unsigned DEF_REP_WIDTH = 16;
    localparam int unsigned MODE_WIDTH    = 2;

    localparam logic [MODE_WIDTH-1:0] MODE_ONESHOT  = 2'd0;
    localparam logic [MODE_WIDTH-1:0] MODE_RETRIG   = 2'd1;
    localparam logic [MODE_WIDTH-1:0] MODE_BURST    = 2'd2;
    localparam logic [MODE_WIDTH-1:0] MODE_RESERVED = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OFFSET = 2'd1,
        ST_HIGH   = 2'd2,
        ST_GAP    = 2'd3
    } state_t;

    // Mode 3 is reserved and never starts a sequence.
    function automatic logic mode_valid(input logic [MODE_WIDTH-1:0] mode);
        return mode != MODE_RESERVED;
    endfunction

endpackage

// File: rtl/pulse_generator_prog_tick_down_counter.sv
// Loadable down-counter that stops at zero; shared by all timed phases.
module tick_down_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic             zero_c
);

    logic [WIDTH-1:0] count;

    // Load has priority over counting; the count holds once it reaches zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/pulse_generator_prog.sv
// Runtime-programmable delayed pulse generator: one-shot, retriggerable or periodic burst.
module pulse_generator_prog
    import pulse_gen_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH,
    parameter int unsigned REP_WIDTH = DEF_REP_WIDTH
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic                  i_Trigger,
    input  logic                  i_Abort,
    input  logic [MODE_WIDTH-1:0] i_Mode,
    input  logic [CNT_WIDTH-1:0]  i_Offset,
    input  logic [CNT_WIDTH-1:0]  i_Width,
    input  logic [CNT_WIDTH-1:0]  i_Period,
    input  logic [REP_WIDTH-1:0]  i_Repeat,
    output logic                  o_Signal,
    output logic                  o_Busy,
    output logic                  o_Done,
    output logic                  o_Cfg_Err,
    output logic [REP_WIDTH-1:0]  o_Pulse_Count
);

    state_t state, state_next;

    logic                  trig_q;
    logic                  trig_edge;

    logic [MODE_WIDTH-1:0] mode_q;
    logic [CNT_WIDTH-1:0]  offset_q;
    logic [CNT_WIDTH-1:0]  width_q;
    logic [CNT_WIDTH-1:0]  period_q;
    logic [REP_WIDTH-1:0]  repeat_q;

    logic                  cnt_load;
    logic [CNT_WIDTH-1:0]  cnt_value;
    logic                  cnt_en;
    logic                  cnt_zero;

    logic                  accept;
    logic                  cfg_ok;
    logic                  pulse_start;
    logic                  done_set;
    logic                  burst_last;
    logic                  retrig;

    assign trig_edge  = i_Trigger & ~trig_q;
    assign cfg_ok     = (i_Width != '0) && mode_valid(i_Mode) &&
                        !((i_Mode == MODE_BURST) && (i_Period <= i_Width));
    assign burst_last = (repeat_q != '0) && (o_Pulse_Count >= repeat_q);
    assign retrig     = trig_edge && (mode_q == MODE_RETRIG);

    // One counter serves OFFSET, HIGH and GAP since only one phase runs at a time.
    tick_down_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_counter (
        .clk        (i_Clk),
        .rst        (i_Rst),
        .load       (cnt_load),
        .load_value (cnt_value),
        .enable     (cnt_en),
        .zero_c     (cnt_zero)
    );

    // Trigger edge-detect register.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            trig_q <= 1'b0;
        end else begin
            trig_q <= i_Trigger;
        end
    end

    // State register.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, counter control and event strobes; abort outranks any trigger.
    always_comb begin
        state_next  = state;
        cnt_load    = 1'b0;
        cnt_value   = '0;
        cnt_en      = 1'b0;
        accept      = 1'b0;
        pulse_start = 1'b0;
        done_set    = 1'b0;
        if (i_Abort) begin
            state_next = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (trig_edge) begin
                        accept = 1'b1;
                        if (cfg_ok) begin
                            cnt_load = 1'b1;
                            if (i_Offset == '0) begin
                                state_next  = ST_HIGH;
                                cnt_value   = i_Width - CNT_WIDTH'(1);
                                pulse_start = 1'b1;
                            end else begin
                                state_next = ST_OFFSET;
                                cnt_value  = i_Offset - CNT_WIDTH'(1);
                            end
                        end
                    end
                end
                ST_OFFSET: begin
                    cnt_en = 1'b1;
                    if (retrig) begin
                        cnt_load  = 1'b1;
                        cnt_value = offset_q - CNT_WIDTH'(1);
                    end else if (cnt_zero) begin
                        state_next  = ST_HIGH;
                        cnt_load    = 1'b1;
                        cnt_value   = width_q - CNT_WIDTH'(1);
                        pulse_start = 1'b1;
                    end
                end
                ST_HIGH: begin
                    cnt_en = 1'b1;
                    if (retrig) begin
                        cnt_load  = 1'b1;
                        cnt_value = width_q - CNT_WIDTH'(1);
                    end else if (cnt_zero) begin
                        if ((mode_q == MODE_BURST) && !burst_last) begin
                            state_next = ST_GAP;
                            cnt_load   = 1'b1;
                            cnt_value  = period_q - width_q - CNT_WIDTH'(1);
                        end else begin
                            state_next = ST_IDLE;
                            done_set   = 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    cnt_en = 1'b1;
                    if (cnt_zero) begin
                        state_next  = ST_HIGH;
                        cnt_load    = 1'b1;
                        cnt_value   = width_q - CNT_WIDTH'(1);
                        pulse_start = 1'b1;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Configuration is captured only in the accept cycle.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            mode_q   <= MODE_ONESHOT;
            offset_q <= '0;
            width_q  <= '0;
            period_q <= '0;
            repeat_q <= '0;
        end else if (accept) begin
            mode_q   <= i_Mode;
            offset_q <= i_Offset;
            width_q  <= i_Width;
            period_q <= i_Period;
            repeat_q <= i_Repeat;
        end
    end

    // Registered outputs derived from the upcoming state and strobes.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            o_Signal      <= 1'b0;
            o_Busy        <= 1'b0;
            o_Done        <= 1'b0;
            o_Cfg_Err     <= 1'b0;
            o_Pulse_Count <= '0;
        end else begin
            o_Signal <= (state_next == ST_HIGH);
            o_Busy   <= (state_next != ST_IDLE);
            o_Done   <= done_set;
            if (accept) begin
                o_Cfg_Err     <= ~cfg_ok;
                o_Pulse_Count <= pulse_start ? REP_WIDTH'(1) : '0;
            end else if (pulse_start && (o_Pulse_Count != '1)) begin
                o_Pulse_Count <= o_Pulse_Count + REP_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_pulse_generator_prog.sv
// Bench for pulse_generator_prog: table-driven sequences plus hand-written corner cases.
module tb_pulse_generator_prog;

    localparam int unsigned CW = 38;
    localparam int unsigned RW = 16;

    logic          clk = 1'b0;
    logic          rst_s;
    logic          trig_s;
    logic          abort_s;
    logic [1:0]    mode_s;
    logic [CW-1:0] off_s;
    logic [CW-1:0] wid_s;
    logic [CW-1:0] per_s;
    logic [RW-1:0] rep_s;
    logic          sig;
    logic          busy;
    logic          done;
    logic          cfg_err;
    logic [RW-1:0] pcnt;

    int errors = 0;
    int checks = 0;
    string cur_name = "reset";

    typedef struct {
        int            k;
        logic          sig;
        logic          busy;
        logic          done;
        logic          cfg;
        logic [RW-1:0] cnt;
    } obs_t;

    typedef struct {
        logic [1:0] mode;
        int         off;
        int         wid;
        int         per;
        int         rep;
        logic       err;
        int         done_k;
        int         pulses;
    } vec_t;

    obs_t exp_q[$];
    vec_t tbl[9];

    always #5 clk = ~clk;

    pulse_generator_prog dut (
        .i_Clk         (clk),
        .i_Rst         (rst_s),
        .i_Trigger     (trig_s),
        .i_Abort       (abort_s),
        .i_Mode        (mode_s),
        .i_Offset      (off_s),
        .i_Width       (wid_s),
        .i_Period      (per_s),
        .i_Repeat      (rep_s),
        .o_Signal      (sig),
        .o_Busy        (busy),
        .o_Done        (done),
        .o_Cfg_Err     (cfg_err),
        .o_Pulse_Count (pcnt)
    );

    // Expected outputs k cycles after the accepting edge, from pulse start times.
    function automatic obs_t exp_at(vec_t v, int k);
        obs_t o;
        int   np;
        int   s;
        o.k    = k;
        o.sig  = 1'b0;
        o.busy = 1'b0;
        o.done = 1'b0;
        o.cfg  = v.err;
        o.cnt  = '0;
        if (!v.err) begin
            np = (v.mode == 2'd2) ? v.rep : 1;
            for (int j = 0; j < np; j++) begin
                s = 1 + v.off + j * v.per;
                if (s <= k) o.cnt = o.cnt + 16'(1);
                if ((k >= s) && (k < s + v.wid)) o.sig = 1'b1;
            end
            o.busy = (k < v.done_k);
            o.done = (k == v.done_k);
        end
        return o;
    endfunction

    task automatic push_seq(input vec_t v, input int n);
        for (int k = 1; k <= n; k++) exp_q.push_back(exp_at(v, k));
    endtask

    task automatic push_obs(input int k, input logic s, input logic b, input logic d,
                            input logic c, input int cnt);
        obs_t o;
        o.k    = k;
        o.sig  = s;
        o.busy = b;
        o.done = d;
        o.cfg  = c;
        o.cnt  = 16'(cnt);
        exp_q.push_back(o);
    endtask

    task automatic drive_cfg(input logic [1:0] m, input int o, input int w, input int p, input int r);
        mode_s = m;
        off_s  = 38'(o);
        wid_s  = 38'(w);
        per_s  = 38'(p);
        rep_s  = 16'(r);
    endtask

    // Advance one clock, then compare against the next scoreboard entry if any.
    task automatic cycle();
        obs_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({sig, busy, done, cfg_err, pcnt} !== {e.sig, e.busy, e.done, e.cfg, e.cnt}) begin
                errors++;
                $display("FAIL %s k=%0d: got sig=%b busy=%b done=%b cfg=%b cnt=%0d, want sig=%b busy=%b done=%b cfg=%b cnt=%0d",
                         cur_name, e.k, sig, busy, done, cfg_err, pcnt,
                         e.sig, e.busy, e.done, e.cfg, e.cnt);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        int   n;

        //             mode  off wid per rep err   done pulses
        tbl[0] = '{2'd0, 3, 5, 0, 0, 1'b0, 9,  1};
        tbl[1] = '{2'd2, 1, 2, 5, 3, 1'b0, 14, 3};
        tbl[2] = '{2'd1, 2, 3, 0, 0, 1'b0, 6,  1};
        tbl[3] = '{2'd0, 0, 1, 0, 0, 1'b0, 2,  1};
        tbl[4] = '{2'd0, 2, 0, 0, 0, 1'b1, 0,  0};
        tbl[5] = '{2'd2, 0, 4, 4, 2, 1'b1, 0,  0};
        tbl[6] = '{2'd3, 0, 2, 0, 0, 1'b1, 0,  0};
        tbl[7] = '{2'd0, 0, 2, 0, 0, 1'b0, 3,  1};
        tbl[8] = '{2'd2, 0, 1, 2, 2, 1'b0, 4,  2};

        rst_s   = 1'b1;
        trig_s  = 1'b0;
        abort_s = 1'b0;
        drive_cfg(2'd0, 0, 1, 0, 0);
        cycle();
        cycle();
        push_obs(0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        cycle();
        rst_s = 1'b0;
        push_obs(1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        cycle();

        for (int i = 0; i < 9; i++) begin
            v        = tbl[i];
            cur_name = $sformatf("vec%0d", i);
            n        = v.err ? 3 : v.done_k + 2;
            drive_cfg(v.mode, v.off, v.wid, v.per, v.rep);
            trig_s = 1'b1;
            push_seq(v, n);
            cycle();
            trig_s = 1'b0;
            drive_cfg(2'd3, 7, 0, 1, 9);
            repeat (n - 1) cycle();
            checks++;
            if (pcnt !== 16'(v.pulses)) begin
                errors++;
                $display("FAIL %s final_cnt: got %0d want %0d", cur_name, pcnt, v.pulses);
            end
        end

        cur_name = "retrigger";
        drive_cfg(2'd1, 0, 4, 0, 0);
        for (int k = 1; k <= 9; k++) push_obs(k, k <= 7, k <= 7, k == 8, 1'b0, 1);
        trig_s = 1'b1;
        cycle();
        trig_s = 1'b0;
        cycle();
        cycle();
        trig_s = 1'b1;
        cycle();
        trig_s = 1'b0;
        repeat (5) cycle();

        cur_name = "abort_burst";
        v = '{2'd2, 0, 2, 4, 3, 1'b0, 1000, 3};
        drive_cfg(2'd2, 0, 2, 4, 0);
        push_seq(v, 9);
        for (int k = 10; k <= 12; k++) push_obs(k, 1'b0, 1'b0, 1'b0, 1'b0, 3);
        trig_s = 1'b1;
        cycle();
        trig_s = 1'b0;
        repeat (8) cycle();
        abort_s = 1'b1;
        cycle();
        abort_s = 1'b0;
        cycle();
        cycle();

        cur_name = "abort_with_trigger";
        for (int k = 1; k <= 3; k++) push_obs(k, 1'b0, 1'b0, 1'b0, 1'b0, 3);
        abort_s = 1'b1;
        trig_s  = 1'b1;
        cycle();
        abort_s = 1'b0;
        cycle();
        cycle();
        trig_s = 1'b0;
        cycle();

        cur_name = "reset_in_offset";
        drive_cfg(2'd0, 5, 2, 0, 0);
        push_obs(1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        push_obs(2, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        push_obs(3, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        push_obs(4, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        trig_s = 1'b1;
        cycle();
        trig_s = 1'b0;
        cycle();
        rst_s = 1'b1;
        cycle();
        rst_s = 1'b0;
        cycle();

        cur_name = "held_trigger";
        v = '{2'd0, 0, 2, 0, 0, 1'b0, 3, 1};
        drive_cfg(2'd0, 0, 2, 0, 0);
        push_seq(v, 20);
        trig_s = 1'b1;
        repeat (20) cycle();
        trig_s = 1'b0;
        cycle();

        cur_name = "back_to_back";
        v = '{2'd0, 1, 2, 0, 0, 1'b0, 4, 1};
        drive_cfg(2'd0, 1, 2, 0, 0);
        push_seq(v, 4);
        trig_s = 1'b1;
        cycle();
        trig_s = 1'b0;
        repeat (3) cycle();
        v = '{2'd0, 0, 3, 0, 0, 1'b0, 4, 1};
        drive_cfg(2'd0, 0, 3, 0, 0);
        push_seq(v, 5);
        trig_s = 1'b1;
        cycle();
        trig_s = 1'b0;
        repeat (4) cycle();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
